// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: walks CMD/ADDR/DUMMY/DATA phases, launches
// the tx/rx shifters, gates SCLK and frames chip select with a 2-cycle hold.
module spi_master_ctrl #(
  parameter int NCS  = 4,
  parameter int LENW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic            rd,
  input  logic            quad,
  input  logic [NCS-1:0]  cs_sel,
  input  logic [LENW-1:0] cmd_len,
  input  logic [LENW-1:0] addr_len,
  input  logic [LENW-1:0] dummy_len,
  input  logic [LENW-1:0] data_len,
  input  logic            sclk_edge,
  input  logic            tx_done,
  input  logic            rx_done,
  input  logic            tx_clk_en,
  input  logic            rx_clk_en,
  output logic            tx_start,
  output logic            rx_start,
  output logic [LENW-1:0] tx_len,
  output logic [LENW-1:0] rx_len,
  output logic            tx_len_upd,
  output logic            rx_len_upd,
  output logic            quad_o,
  output logic            clk_en_o,
  output logic [NCS-1:0]  spi_csn,
  output logic            busy,
  output logic            eot
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA_TX, DATA_RX, CS_HOLD} state_t;

  typedef struct packed {
    logic [LENW-1:0] cmd_len;
    logic [LENW-1:0] addr_len;
    logic [LENW-1:0] dummy_len;
    logic [LENW-1:0] data_len;
    logic            rd;
    logic            quad;
    logic [NCS-1:0]  cs;
  } xfer_t;

  state_t          state, nxt;
  xfer_t           xf, xf_in;
  logic            first_q, hold_q, tx_phase, accept;
  logic [LENW-1:0] dcnt;

  assign xf_in  = '{cmd_len, addr_len, dummy_len, data_len, rd, quad, cs_sel};
  assign accept = (state == IDLE) && start && !abort;

  // First non-empty phase after position 'from' (0: before CMD, 1: after CMD,
  // 2: after ADDR, 3: after DUMMY); an all-empty remainder goes to CS_HOLD.
  function automatic state_t pick(input logic [1:0] from, input xfer_t x);
    pick = CS_HOLD;
    if (x.data_len != '0)                 pick = x.rd ? DATA_RX : DATA_TX;
    if (from < 2'd3 && x.dummy_len != '0) pick = DUMMY;
    if (from < 2'd2 && x.addr_len != '0)  pick = ADDR;
    if (from < 2'd1 && x.cmd_len != '0)   pick = CMD;
  endfunction

  // Done pulses in a phase's launch cycle (first_q) belong to the previous phase.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = pick(2'd0, xf_in);
      CMD:     if (abort) nxt = CS_HOLD; else if (!first_q && tx_done) nxt = pick(2'd1, xf);
      ADDR:    if (abort) nxt = CS_HOLD; else if (!first_q && tx_done) nxt = pick(2'd2, xf);
      DUMMY:   if (abort) nxt = CS_HOLD; else if (dcnt == LENW'(1) && sclk_edge) nxt = pick(2'd3, xf);
      DATA_TX: if (abort || (!first_q && tx_done)) nxt = CS_HOLD;
      DATA_RX: if (abort || (!first_q && rx_done)) nxt = CS_HOLD;
      CS_HOLD: if (hold_q) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      xf      <= '0;
      first_q <= 1'b0;
      hold_q  <= 1'b0;
      dcnt    <= '0;
    end else begin
      state   <= nxt;
      first_q <= (nxt != state);
      hold_q  <= (state == CS_HOLD) ? ~hold_q : 1'b0;
      if (accept) xf <= xf_in;
      if (nxt == DUMMY && state != DUMMY)
        dcnt <= (state == IDLE) ? dummy_len : xf.dummy_len;
      else if (state == DUMMY && sclk_edge)
        dcnt <= dcnt - LENW'(1);
    end
  end

  assign tx_phase   = (state == CMD) || (state == ADDR) || (state == DATA_TX);
  assign tx_start   = tx_phase && first_q;
  assign tx_len_upd = tx_start;
  assign rx_start   = (state == DATA_RX) && first_q;
  assign rx_len_upd = rx_start;
  assign rx_len     = (state == DATA_RX) ? xf.data_len : '0;
  assign quad_o     = ((state == DATA_TX) || (state == DATA_RX)) && xf.quad;
  assign spi_csn    = (state == IDLE) ? '1 : ~xf.cs;
  assign busy       = (state != IDLE);
  assign eot        = (state == CS_HOLD) && hold_q;

  always_comb begin
    tx_len = '0;
    case (state)
      CMD:     tx_len = xf.cmd_len;
      ADDR:    tx_len = xf.addr_len;
      DATA_TX: tx_len = xf.data_len;
      default: tx_len = '0;
    endcase
  end

  // Abort cuts SCLK in the same cycle it is seen.
  always_comb begin
    clk_en_o = 1'b0;
    case (state)
      DUMMY:             clk_en_o = 1'b1;
      CMD, ADDR, DATA_TX: clk_en_o = tx_clk_en;
      DATA_RX:           clk_en_o = rx_clk_en;
      default:           clk_en_o = 1'b0;
    endcase
    if (abort) clk_en_o = 1'b0;
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: expected launches queued at start,
// popped by a monitor on each tx_start/rx_start.
module tb_spi_master_ctrl;
  localparam int NCS = 4, LENW = 16;

  logic clk, rstn, start, abort, rd, quad, sclk_edge, tx_done, rx_done, tx_clk_en, rx_clk_en;
  logic [NCS-1:0] cs_sel, spi_csn;
  logic [LENW-1:0] cmd_len, addr_len, dummy_len, data_len, tx_len, rx_len;
  logic tx_start, rx_start, tx_len_upd, rx_len_upd, quad_o, clk_en_o, busy, eot;

  int errs = 0, nchk = 0, eot_cnt = 0, eot_exp = 0;
  logic [LENW-1:0] txq[$];
  logic [LENW:0]   rxq[$];

  spi_master_ctrl #(.NCS(NCS), .LENW(LENW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .rd(rd), .quad(quad),
    .cs_sel(cs_sel), .cmd_len(cmd_len), .addr_len(addr_len), .dummy_len(dummy_len),
    .data_len(data_len), .sclk_edge(sclk_edge), .tx_done(tx_done), .rx_done(rx_done),
    .tx_clk_en(tx_clk_en), .rx_clk_en(rx_clk_en), .tx_start(tx_start), .rx_start(rx_start),
    .tx_len(tx_len), .rx_len(rx_len), .tx_len_upd(tx_len_upd), .rx_len_upd(rx_len_upd),
    .quad_o(quad_o), .clk_en_o(clk_en_o), .spi_csn(spi_csn), .busy(busy), .eot(eot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (eot) eot_cnt++;
    if (tx_start || tx_len_upd) chk("tx_upd", tx_len_upd, tx_start);
    if (rx_start || rx_len_upd) chk("rx_upd", rx_len_upd, rx_start);
    if (tx_start) begin
      if (txq.size() == 0) chk("tx_unexpected", 1, 0);
      else chk("tx_len", tx_len, txq.pop_front());
    end
    if (rx_start) begin
      if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
      else chk("rx_len_quad", {quad_o, rx_len}, rxq.pop_front());
    end
  end

  task automatic go(input logic [LENW-1:0] c, a, d, dt, input logic r, q, input logic [NCS-1:0] cs);
    cmd_len = c; addr_len = a; dummy_len = d; data_len = dt; rd = r; quad = q; cs_sel = cs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cmd_len = 16'h0063; addr_len = 16'h004d; data_len = 16'h0037; dummy_len = 16'h0002;
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 100 && !tx_start; i++) @(negedge clk);
    chk(tag, tx_start, 1);
  endtask

  task automatic wait_rx(input string tag);
    for (int i = 0; i < 100 && !rx_start; i++) @(negedge clk);
    chk(tag, rx_start, 1);
  endtask

  task automatic tx_pulse(input int gap);
    repeat (gap) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Called in the first CS_HOLD cycle: eot must follow one cycle later.
  task automatic hold_seq(input string tag, input logic [NCS-1:0] csn);
    eot_exp++;
    chk({tag, "_h1_eot"}, eot, 0);
    chk({tag, "_h1_csn"}, spi_csn, csn);
    chk({tag, "_h1_en"}, clk_en_o, 0);
    @(negedge clk);
    chk({tag, "_h2_eot"}, eot, 1);
    chk({tag, "_h2_csn"}, spi_csn, csn);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_csn"}, spi_csn, 4'hF);
  endtask

  initial begin
    rstn = 1'b0; start = 0; abort = 0; rd = 0; quad = 0; sclk_edge = 0; tx_done = 0; rx_done = 0;
    tx_clk_en = 1; rx_clk_en = 1; cs_sel = '0; cmd_len = '0; addr_len = '0; dummy_len = '0; data_len = '0;
    @(negedge clk);
    chk("rst_csn", spi_csn, 4'hF);
    chk("rst_out", {busy, eot, clk_en_o, tx_start, rx_start, quad_o}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // three tx phases, inputs scrambled after start, done in launch cycle ignored
    txq.push_back(16'd8); txq.push_back(16'd24); txq.push_back(16'd32);
    go(16'd8, 16'd24, 16'd0, 16'd32, 1'b0, 1'b0, 4'b0001);
    wait_tx("t1_cmd");
    chk("t1_csn", spi_csn, 4'b1110);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("t1_launch_done_ignored", tx_len, 16'd8);
    tx_clk_en = 1'b0; #1 chk("t1_stall_en", clk_en_o, 0);
    tx_clk_en = 1'b1; #1 chk("t1_run_en", clk_en_o, 1);
    tx_pulse(1);
    wait_tx("t1_addr");
    tx_pulse(2);
    wait_tx("t1_data");
    chk("t1_quad", quad_o, 0);
    tx_pulse(3);
    hold_seq("t1", 4'b1110);

    // dummy window, quad rx, rx stall plus ignored second start
    txq.push_back(16'd8); rxq.push_back({1'b1, 16'd64});
    go(16'd8, 16'd0, 16'd4, 16'd64, 1'b1, 1'b1, 4'b0010);
    wait_tx("t2_cmd");
    chk("t2_cmd_quad", quad_o, 0);
    tx_pulse(1);
    for (int k = 0; k < 4; k++) begin
      chk("t2_dummy_en", clk_en_o, 1);
      chk("t2_dummy_busy", {busy, rx_start}, 2'b10);
      sclk_edge = 1'b1;
      @(negedge clk);
      sclk_edge = 1'b0;
      if (k < 3) @(negedge clk);
    end
    wait_rx("t2_rx");
    chk("t2_rx_quad", quad_o, 1);
    rx_clk_en = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t2_stall_en", clk_en_o, 0);
      @(negedge clk);
    end
    start = 1'b0; rx_clk_en = 1'b1;
    #1 chk("t2_resume_en", clk_en_o, 1);
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    hold_seq("t2", 4'b1101);
    repeat (3) @(negedge clk);
    chk("t2_no_requeue", busy, 0);

    // all lengths zero
    go(16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 4'b0100);
    chk("t3_busy", busy, 1);
    hold_seq("t3", 4'b1011);

    // abort coincident with tx_done in DATA_TX
    txq.push_back(16'd16);
    go(16'd0, 16'd0, 16'd0, 16'd16, 1'b0, 1'b1, 4'b1000);
    wait_tx("t4_data");
    @(negedge clk);
    abort = 1'b1; tx_done = 1'b1;
    #1 chk("t4_abort_en", clk_en_o, 0);
    @(negedge clk);
    abort = 1'b0; tx_done = 1'b0;
    hold_seq("t4", 4'b0111);

    // start and abort together in IDLE
    cmd_len = 16'd8; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_idle", busy, 0);

    // async reset inside DUMMY
    txq.push_back(16'd8);
    go(16'd8, 16'd0, 16'd10, 16'd8, 1'b0, 1'b0, 4'b0001);
    wait_tx("t6_cmd");
    tx_pulse(1);
    sclk_edge = 1'b1; @(negedge clk); sclk_edge = 1'b0;
    chk("t6_in_dummy", clk_en_o, 1);
    #2 rstn = 1'b0;
    #1 chk("t6_rst_csn", spi_csn, 4'hF);
    chk("t6_rst_busy", {busy, clk_en_o}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    chk("eot_count", eot_cnt, eot_exp);
    chk("txq_empty", txq.size(), 0);
    chk("rxq_empty", rxq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
